// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } booth_state_t;

    localparam int MIN_N = 2;

    // Wide enough to hold N+1, the iteration count of the widest mode.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/skip M, then arithmetic right shift of {acc, lq, q_1}.
module booth_step #(
    parameter int W  = 13,
    parameter int LW = 12
) (
    input  logic [W-1:0]  acc,
    input  logic [LW-1:0] lq,
    input  logic          q_1,
    input  logic [W-1:0]  m,
    output logic [W-1:0]  acc_nxt,
    output logic [LW-1:0] lq_nxt,
    output logic          q_1_nxt
);

    logic [W-1:0] sum;

    always_comb begin
        // NOTE: default first so every path assigns sum and no latch is inferred.
        sum = acc;
        case ({lq[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    assign acc_nxt = {sum[W-1], sum[W-1:1]};
    assign lq_nxt  = {sum[0], lq[LW-1:1]};
    assign q_1_nxt = lq[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// Define BOOTH_UNSIGNED_EN to add the signed_mode port and unsigned multiplication.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int N = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic           signed_mode,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] y,
    output logic           busy
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int AW = N + 2;
    localparam int LW = N + 1;
`else
    localparam int AW = N + 1;
    localparam int LW = N;
`endif
    localparam int CW = cnt_width(N);

    if (N < MIN_N) begin : g_bad_n
        $error("booth_mult_seq: N must be at least MIN_N");
    end

    booth_state_t  state;
    logic [AW-1:0] acc;
    logic [LW-1:0] lq;
    logic          q_1;
    logic [AW-1:0] m;
    logic [CW-1:0] cnt;

    logic [AW-1:0] acc_nxt;
    logic [LW-1:0] lq_nxt;
    logic          q_1_nxt;

    booth_step #(
        .W  (AW),
        .LW (LW)
    ) u_step (
        .acc     (acc),
        .lq      (lq),
        .q_1     (q_1),
        .m       (m),
        .acc_nxt (acc_nxt),
        .lq_nxt  (lq_nxt),
        .q_1_nxt (q_1_nxt)
    );

`ifdef BOOTH_UNSIGNED_EN
    logic sgn_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            lq        <= '0;
            q_1       <= 1'b0;
            m         <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
            sgn_q     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef BOOTH_UNSIGNED_EN
                        // Unsigned runs one extra iteration on zero-extended operands.
                        m     <= {{(AW-N){a[N-1] & signed_mode}}, a};
                        lq    <= {1'b0, b};
                        cnt   <= signed_mode ? CW'(N) : CW'(N + 1);
                        sgn_q <= signed_mode;
`else
                        m     <= {{(AW-N){a[N-1]}}, a};
                        lq    <= b;
                        cnt   <= CW'(N);
`endif
                        acc      <= '0;
                        q_1      <= 1'b0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    lq  <= lq_nxt;
                    q_1 <= q_1_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef BOOTH_UNSIGNED_EN
    // In signed mode the spare top bit of lq has only shifted down to lq[0], so skip it.
    logic [AW+LW-1:0] prod;
    logic [1:0]       unused_prod_msbs;

    assign prod             = {acc, lq};
    assign y                = sgn_q ? prod[2*N:1] : prod[2*N-1:0];
    assign unused_prod_msbs = prod[AW+LW-1:2*N+1];
`else
    logic unused_acc_msb;

    assign y              = {acc[N-1:0], lq};
    assign unused_acc_msb = acc[AW-1];
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq at N=12 (default signed build).
module tb_booth_mult_seq;

    localparam int N = 12;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] y;
    logic           busy;

    int n_vec;
    int n_err;

    booth_mult_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until out_valid rises, bounded so a stuck DUT cannot hang the run.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            step();
            guard++;
        end
        check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                       input logic [2*N-1:0] exp);
        int cyc;
        out_ready = 1'b1;
        wait_ready(tag);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        wait_out(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(N));
        check({tag, "_y"}, 32'(y), 32'(exp));
        step();
        check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        step();
        rst = 1'b1;

        run("mul_7_m3", 12'd7, 12'hFFD, 24'hFFFFEB);
        run("mul_min_min", 12'h800, 12'h800, 24'h400000);
        run("mul_max_min", 12'h7FF, 12'h800, 24'hC00800);
        run("mul_zero", 12'h000, 12'h5A5, 24'h000000);
        run("mul_m1_1", 12'hFFF, 12'h001, 24'hFFFFFF);

        // Back-pressure: 100 * -5 = -500 held for five cycles.
        out_ready = 1'b0;
        a         = 12'd100;
        b         = 12'hFFB;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(cyc);
        check("stall_latency", 32'(cyc), 32'(N));
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_y", 32'(y), 32'h00FFFE0C);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("stall_release_in_ready", 32'(in_ready), 32'd1);
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_busy", 32'(busy), 32'd0);

        // New operands offered mid-calculation must wait for IDLE.
        a        = 12'd3;
        b        = 12'd4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a        = 12'd9;
        b        = 12'd9;
        in_valid = 1'b1;
        wait_out(cyc);
        check("ignore_latency", 32'(cyc), 32'(N - 3));
        check("ignore_first_y", 32'(y), 32'd12);
        step();
        check("ignore_idle_in_ready", 32'(in_ready), 32'd1);
        check("ignore_idle_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("ignore_second_busy", 32'(busy), 32'd1);
        wait_out(cyc);
        check("ignore_second_latency", 32'(cyc), 32'(N));
        check("ignore_second_y", 32'(y), 32'd81);
        step();

        // Asynchronous reset at iteration 6 abandons the operation.
        a        = 12'd11;
        b        = 12'd13;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b1;
        check("arst_hold_valid", 32'(out_valid), 32'd0);

        run("after_rst_5_6", 12'd5, 12'd6, 24'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier. It is the next generation of the team's fixed 12-bit, externally sequenced Booth datapath.
- Holds its own control FSM and iteration counter, and uses valid/ready handshakes on input and output.
- Overflow-safe accumulator; operand width set by a parameter.
- Sits between an operand producer (e.g. register file or ALU issue) and a result consumer. Multiplies signed two's-complement operands by default.

Parameters:
- N, 12, operand width in bits; legal range N >= 2. Product width is 2N.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair a/b is valid.
- in_ready  out  1  block can accept operands.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- out_valid  out  1  product y is valid.
- out_ready  in  1  consumer accepts y.
- y  out  2N  product.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; accumulator, multiplier register, Q_1, M and counter cleared.
  - Outputs: in_ready=1, out_valid=0, y=0, busy=0.
  - Reset is honoured at any time, including mid-CALC: the operation is abandoned and no output is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready, latch M = a sign-extended to N+1 bits.
  - Load ACC (N+1 bits)=0, LQ=b, Q_1=0, counter=N, then go to CALC.
- CALC (one iteration per cycle):
  - Examine {LQ[0],Q_1}:
    - 01: ACC+M.
    - 10: ACC-M.
    - 00/11: ACC unchanged.
  - In the same cycle, arithmetic-shift {ACC,LQ,Q_1} right by 1. ACC's MSB is replicated.
  - counter decrements. When the counter reaches 1 and that iteration completes, go to DONE.
- DONE:
  - out_valid=1, y={ACC[N-1:0],LQ}, held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- Latency:
  - Accept edge T; iterations on edges T+1..T+N; out_valid high from edge T+N.
  - Best-case throughput is one product per N+2 cycles.
- Handshake rules:
  - in_ready=0 in CALC and DONE. in_valid there is ignored, and a/b changes have no effect.
  - y and out_valid must not change while out_valid=1 && out_ready=0.
  - out_ready in IDLE/CALC is ignored.
- Arithmetic:
  - The N+1-bit accumulator prevents overflow for M = -2^(N-1).
  - The full signed 2N-bit product is exact for all operand pairs, including (-2^(N-1))².
- y holds its last value in IDLE after a transfer, but is don't-care while out_valid=0 (bench must not check it).

Optional Feature:
- Macro: BOOTH_UNSIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled on the accept edge.
  - signed_mode=0: a and b are zero-extended to N+1 bits.
  - ACC widens to N+2 bits and N+1 iterations run. Latency becomes N+1 and y is the exact unsigned 2N-bit product.
  - signed_mode=1: behaviour is identical to the default.
- Undefined: no signed_mode port; signed only; N iterations.

Decomposition:
- Package booth_pkg:
  - state enum booth_state_t {IDLE, CALC, DONE}.
  - Localparam MIN_N=2.
  - Function for the counter width, $clog2(N+2).
- Sub-module booth_step (combinational, parametrised on accumulator width W):
  - Inputs: ACC, LQ, Q_1, M.
  - Outputs: next ACC, next LQ, next Q_1, i.e. the add/sub/none then arithmetic shift.
  - Instantiated once in booth_mult_seq.

Test Plan (N=12):
- a=7, b=-3 (12'hFFD), out_ready=1 -> out_valid exactly 12 cycles after accept, y=24'hFFFFEB.
- a=-2048, b=-2048 -> y=24'h400000; a=2047, b=-2048 -> y=24'hC00800; a=0, b=12'h5A5 -> y=0.
- Hold out_ready=0 for 5 cycles in DONE -> y and out_valid stable each cycle, in_ready=0. Raise out_ready -> next cycle IDLE, in_ready=1.
- Assert in_valid with new a/b during CALC -> ignored; the first result is unaffected. The second pair is accepted only after returning to IDLE.
- Drop rst for 1 cycle at iteration 6 -> in_ready=1, out_valid=0, busy=0 immediately (asynchronous). The next operation, a=5 b=6, gives y=30.
- BOOTH_UNSIGNED_EN defined, signed_mode=0, a=b=12'hFFF -> y=24'hFFE001 after 13 cycles. signed_mode=1 with the same operands -> y=24'h000001.
